float_to_fixed_seq: RTL
=======================

// Module: float_to_fixed_seq
// PURPOSE
//  Multi-cycle IEEE-754 single-precision to signed fixed-point converter.
//  Sits directly upstream of the unrolled CORDIC: it consumes the scaled
//  angle (x-128)/128 from the float multiplier and produces the 22-bit
//  fixed-point angle the CORDIC expects.
//  It uses the same enable/done handshake as the Task6 arithmetic units.
// PARAMETERS
//  WIDTH     22  fixed-point result width, two's complement
//  FRAC      20  fractional bits (default format Q1.20, range [-2.0, 2.0))
// PORTS
//  clk       in   1      rising-edge clock
//  reset     in   1      synchronous, active-high reset
//  enable    in   1      level request; data sampled when high in IDLE
//  data      in   32     IEEE-754 single-precision operand
//  result    out  WIDTH  fixed-point value; held until next conversion ends
//  done      out  1      conversion complete (see handshake)
//  overflow  out  1      |value| out of range or +/-Inf; result saturated
//  invalid   out  1      NaN operand; result forced to 0
// BEHAVIOUR
//  - Reset (synchronous, active-high): state=IDLE; result, done, overflow
//    and invalid are all 0 after the edge. Reset mid-conversion aborts it.
//  - FSM: IDLE -> UNPACK -> ALIGN -> ROUND -> DONE.
//    IDLE:   on enable=1, register data and go to UNPACK.
//    UNPACK: sign s=data[31], exponent e=data[30:23], mantissa m={1,data[22:0]}.
//            Classify the operand: e==0 is zero/denormal, giving 0.
//            e==255 with frac!=0 is NaN. e==255 with frac==0 is Inf.
//    ALIGN:  shift amount sh = e - 127 - 23 + FRAC.
//            sh>=0: left-shift m; flag overflow if any bit reaches bit WIDTH-1.
//            sh<0: right-shift m by -sh (clamped at 31).
//            Keep guard and sticky bits from the bits shifted out.
//    ROUND:  apply the rounding mode to the magnitude. Overflow if the
//            magnitude is >= 2^(WIDTH-1), including a carry from rounding.
//            Negate when s=1. -2^(WIDTH-1) is reachable only on an exact -2.0.
//            Saturate to 0x1FFFFF / 0x200000 (defaults) by sign on overflow.
//            Register result, overflow and invalid.
//    DONE:   done=1. Stay while enable=1. Go to IDLE on the first cycle
//            enable=0, so done is always high for at least 1 cycle.
//  - Latency: enable sampled in IDLE at edge N gives done=1 after edge N+4.
//    Throughput is one conversion per 5+ cycles; a new request needs enable
//    to be seen low first.
//  - enable dropped mid-conversion: the conversion still completes and done
//    pulses for 1 cycle.
//  - data changes after capture are ignored.
//  - Special cases:
//    Inf gives a saturated result with overflow=1.
//    NaN gives result 0 with invalid=1 and overflow=0.
//    -0.0 gives result 0.
//    Underflow (all bits shifted out) gives 0, or +/-1 LSB by rounding.
//  - overflow and invalid are valid while done=1 and hold with result.
// CONFIGURATION
//  FLOAT_FIXED_RNE_EN defined:
//    round-to-nearest-even on magnitude, using guard and sticky bits.
//    An exact tie rounds to an even LSB.
//  FLOAT_FIXED_RNE_EN undefined:
//    truncate magnitude (round toward zero); guard and sticky are ignored.
//    ROUND state is kept, so latency is identical in both builds.
// TESTING
//  1. 0x3F000000 (0.5), enable held -> result=0x080000, done at edge N+4,
//     overflow=0, invalid=0.
//  2. 0xBF800000 (-1.0) -> result=0x300000, flags 0; done stays high until
//     enable=0, then the FSM returns to IDLE.
//  3. 0x40800000 (4.0) -> result=0x1FFFFF, overflow=1;
//     0xFF800000 (-Inf) -> result=0x200000, overflow=1.
//  4. 0x7FC00000 (NaN) -> result=0, invalid=1, overflow=0.
//  5. 0x35000001 (just above 2^-21): RNE build gives 0x000001, truncate build
//     gives 0x000000. 0x3FFFFFFF: RNE build gives 0x1FFFFF with overflow=1;
//     truncate build gives 0x1FFFFF with overflow=0.
//  6. reset=1 for 1 cycle while in ALIGN -> next cycle state=IDLE, done=0,
//     result=0. A following request with 0x3C000000 gives 0x002000.

Source files
------------

// File: rtl/float_to_fixed_seq_if.sv
// +----------------------------------------------------------------------------+
// | Module      : float_to_fixed_seq_if                                        |
// | Description : enable/done handshake bundle for float_to_fixed_seq          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface float_to_fixed_seq_if #(
  parameter int WIDTH = 22
);
  logic             enable;
  logic [31:0]      data;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             overflow;
  logic             invalid;

  modport master (
    output enable, data,
    input  result, done, overflow, invalid
  );

  modport slave (
    input  enable, data,
    output result, done, overflow, invalid
  );
endinterface

`default_nettype wire

// File: rtl/float_to_fixed_seq.sv
// +----------------------------------------------------------------------------+
// | Module      : float_to_fixed_seq                                           |
// | Description : multi-cycle IEEE-754 single to signed fixed-point converter; |
// |               FLOAT_FIXED_RNE_EN selects round-to-nearest-even (default    |
// |               build truncates toward zero)                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module float_to_fixed_seq #(
  parameter int WIDTH = 22,
  parameter int FRAC  = 20
) (
  input  wire logic           clk,
  input  wire logic           reset,
  float_to_fixed_seq_if.slave bus
);

  localparam int                      MAG_W   = WIDTH + 24;
  localparam logic signed [10:0]      SH_BIAS = 11'(FRAC - 150);
  localparam logic signed [10:0]      SH_OVF  = 11'(WIDTH - 24);
  localparam logic [MAG_W-1:0]        LIMIT   = MAG_W'(1) << (WIDTH - 1);
  localparam logic [WIDTH-1:0]        SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ROUND  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t r_state, w_next;

  logic [31:0]       r_data;
  logic              r_sign, r_zero, r_inf, r_nan;
  logic [7:0]        r_exp;
  logic [23:0]       r_mant;
  logic [MAG_W-1:0]  r_mag;
  logic              r_guard, r_sticky, r_aovf;
  logic [WIDTH-1:0]  r_result;
  logic              r_ovf, r_inv, r_done;

  logic signed [10:0] w_sh;
  logic [10:0]        w_neg;
  logic [4:0]         w_rsh;
  logic [55:0]        w_rshift;
  logic [MAG_W-1:0]   w_lshift;
  logic               w_lovf;
  logic               w_inc;
  logic [MAG_W-1:0]   w_mag_rnd;
  logic               w_exact_min;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.enable) w_next = S_UNPACK;
      S_UNPACK: w_next = S_ALIGN;
      S_ALIGN:  w_next = S_ROUND;
      S_ROUND:  w_next = S_DONE;
      S_DONE:   if (!bus.enable) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Alignment: sh = e - 150 + FRAC; right shifts keep guard/sticky below the LSB.
  always_comb begin
    w_sh     = $signed({3'b000, r_exp}) + SH_BIAS;
    w_neg    = 11'(-w_sh);
    w_rsh    = (w_neg > 11'd31) ? 5'd31 : w_neg[4:0];
    w_rshift = {r_mant, 32'b0} >> w_rsh;
    w_lshift = MAG_W'(r_mant) << w_sh[5:0];
    w_lovf   = (w_sh >= SH_OVF);
  end

  always_comb begin
`ifdef FLOAT_FIXED_RNE_EN
    w_inc = r_guard & (r_sticky | r_mag[0]);
`else
    w_inc = 1'b0;
`endif
    w_mag_rnd   = r_mag + MAG_W'(w_inc);
    // Only an exactly representable -2^(WIDTH-1) escapes the overflow flag.
    w_exact_min = r_sign && (w_mag_rnd == LIMIT) && !r_guard && !r_sticky;
    w_ovf       = !r_nan && (r_aovf || ((w_mag_rnd >= LIMIT) && !w_exact_min));
    w_res       = '0;
    if (r_nan)       w_res = '0;
    else if (w_ovf)  w_res = r_sign ? SAT_NEG : SAT_POS;
    else if (r_sign) w_res = WIDTH'(-w_mag_rnd[WIDTH-1:0]);
    else             w_res = w_mag_rnd[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data   <= '0;
      r_sign   <= 1'b0;
      r_zero   <= 1'b0;
      r_inf    <= 1'b0;
      r_nan    <= 1'b0;
      r_exp    <= '0;
      r_mant   <= '0;
      r_mag    <= '0;
      r_guard  <= 1'b0;
      r_sticky <= 1'b0;
      r_aovf   <= 1'b0;
      r_result <= '0;
      r_ovf    <= 1'b0;
      r_inv    <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.enable) r_data <= bus.data;
        end
        S_UNPACK: begin
          r_sign <= r_data[31];
          r_exp  <= r_data[30:23];
          r_mant <= {1'b1, r_data[22:0]};
          r_zero <= (r_data[30:23] == 8'd0);
          r_inf  <= (r_data[30:23] == 8'hFF) && (r_data[22:0] == 23'd0);
          r_nan  <= (r_data[30:23] == 8'hFF) && (r_data[22:0] != 23'd0);
        end
        S_ALIGN: begin
          if (r_zero || r_inf || r_nan) begin
            r_mag    <= '0;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_aovf   <= r_inf;
          end else if (!w_sh[10]) begin
            r_mag    <= w_lshift;
            r_guard  <= 1'b0;
            r_sticky <= 1'b0;
            r_aovf   <= w_lovf;
          end else begin
            r_mag    <= MAG_W'(w_rshift[55:32]);
            r_guard  <= w_rshift[31];
            r_sticky <= |w_rshift[30:0];
            r_aovf   <= 1'b0;
          end
        end
        S_ROUND: begin
          r_result <= w_res;
          r_ovf    <= w_ovf;
          r_inv    <= r_nan;
        end
        default: ;
      endcase
    end
  end

  assign bus.result   = r_result;
  assign bus.done     = r_done;
  assign bus.overflow = r_ovf;
  assign bus.invalid  = r_inv;

endmodule

`default_nettype wire
